// File: rtl/vga_timing_core.sv
// VGA raster timing: pixel/line counters, sync, blanking, line/frame strobes and an animation
// frame counter. Every output is registered and describes the same pixel as hpos/vpos.
module vga_timing_core #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_BOTTOM  = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_TOP     = 33,
  parameter logic        SYNC_ACT  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [1:0] frame_step,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame
);

  localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0] HMax       = 10'(HTotal - 1);
  localparam logic [9:0] VMax       = 10'(VTotal - 1);
  localparam logic [9:0] HDisp      = 10'(H_DISPLAY);
  localparam logic [9:0] VDisp      = 10'(V_DISPLAY);
  localparam logic [9:0] HSyncStart = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncStart = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] VSyncEnd   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [9:0] frame_q, frame_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap, frame_wrap;

  // Derived outputs are decoded from the next counter values so they land on the same edge.
  always_comb begin
    h_wrap     = (hpos_q == HMax);
    v_wrap     = (vpos_q == VMax);
    frame_wrap = h_wrap && v_wrap;

    hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (h_wrap) begin
      vpos_d = v_wrap ? 10'd0 : vpos_q + 10'd1;
    end

    frame_d = frame_wrap ? frame_q + {8'd0, frame_step} : frame_q;

    hsync_d = ((hpos_d >= HSyncStart) && (hpos_d <= HSyncEnd)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d = ((vpos_d >= VSyncStart) && (vpos_d <= VSyncEnd)) ? SYNC_ACT : ~SYNC_ACT;
    display_on_d  = (hpos_d < HDisp) && (vpos_d < VDisp);
    line_start_d  = h_wrap;
    frame_start_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q        <= 10'd0;
      vpos_q        <= 10'd0;
      frame_q       <= 10'd0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_q       <= frame_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame       = frame_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
